// File: rtl/fa_cell.sv
// fa_cell: one-bit full adder, purely combinational.
// Ports:
//   a, b  - addend bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term, shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// full_adder: MP_WIDTH-bit ripple-carry adder with a registered result.
// {ocout, osum} holds ia + ib + icin, sampled on the previous rising edge.
// Ports:
//   iclk   - clock, rising edge
//   irst_n - synchronous active-low reset, clears osum/ocout
//   ia, ib - unsigned operands, MP_WIDTH bits
//   icin   - carry in
//   osum   - registered sum, MP_WIDTH bits
//   ocout  - registered carry out
module full_adder #(
    parameter int MP_WIDTH = 4
) (
    input  logic                iclk,
    input  logic                irst_n,
    input  logic [MP_WIDTH-1:0] ia,
    input  logic [MP_WIDTH-1:0] ib,
    input  logic                icin,
    output logic [MP_WIDTH-1:0] osum,
    output logic                ocout
);

    logic [MP_WIDTH:0]   c;
    logic [MP_WIDTH-1:0] s;

    assign c[0] = icin;

    // Carry ripples from bit 0 upward through one cell per bit.
    for (genvar k = 0; k < MP_WIDTH; k++) begin : g_cell
        fa_cell u_cell (
            .a  (ia[k]),
            .b  (ib[k]),
            .ci (c[k]),
            .s  (s[k]),
            .co (c[k+1])
        );
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            osum  <= '0;
            ocout <= 1'b0;
        end else begin
            osum  <= s;
            ocout <= c[MP_WIDTH];
        end
    end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  a4, b4, s4;
    logic        c4, co4;
    logic        a1, b1, s1, c1, co1;
    logic [15:0] a16, b16, s16;
    logic        c16, co16;

    full_adder #(.MP_WIDTH(4)) dut4 (
        .iclk(clk), .irst_n(rst_n), .ia(a4), .ib(b4), .icin(c4), .osum(s4), .ocout(co4)
    );
    full_adder #(.MP_WIDTH(1)) dut1 (
        .iclk(clk), .irst_n(rst_n), .ia(a1), .ib(b1), .icin(c1), .osum(s1), .ocout(co1)
    );
    full_adder #(.MP_WIDTH(16)) dut16 (
        .iclk(clk), .irst_n(rst_n), .ia(a16), .ib(b16), .icin(c16), .osum(s16), .ocout(co16)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h want %h", nm, act, exp);
    endtask

    // Behavioural model: the result of an edge is the plain integer sum of
    // the inputs seen at that edge, or zero if reset was low.
    logic        mvalid = 1'b0;
    logic [4:0]  exp4;
    logic [1:0]  exp1;
    logic [16:0] exp16;

    always @(posedge clk) begin
        int t4, t1, t16;
        t4  = int'(a4) + int'(b4) + int'(c4);
        t1  = int'(a1) + int'(b1) + int'(c1);
        t16 = int'(a16) + int'(b16) + int'(c16);
        exp4   = rst_n ? 5'(t4)   : 5'd0;
        exp1   = rst_n ? 2'(t1)   : 2'd0;
        exp16  = rst_n ? 17'(t16) : 17'd0;
        mvalid = 1'b1;
    end

    // Single compare process, every cycle once the first edge has happened.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_w4",  32'({co4, s4}),   32'(exp4));
            chk("model_w1",  32'({co1, s1}),   32'(exp1));
            chk("model_w16", 32'({co16, s16}), 32'(exp16));
        end
    end

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic c, input logic r);
        @(negedge clk);
        rst_n = r;
        a4 = a; b4 = b; c4 = c;
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] es, input logic ec);
        step(a, b, c, 1'b1);
        chk({nm, "_sum"},  32'(s4),  32'(es));
        chk({nm, "_cout"}, 32'(co4), 32'(ec));
    endtask

    // Back-to-back sequence; entry 4 is a reset edge.
    logic [3:0] bb_a [8] = '{4'd1, 4'd3, 4'd9, 4'd5, 4'd8, 4'd6, 4'd14, 4'd12};
    logic [3:0] bb_b [8] = '{4'd2, 4'd4, 4'd9, 4'd5, 4'd8, 4'd7, 4'd1,  4'd3};
    logic       bb_c [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       bb_r [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] bb_e [8] = '{5'd3, 5'd8, 5'd18, 5'd11, 5'd0, 5'd13, 5'd16, 5'd15};

    initial begin
        rst_n = 1'b0;
        a4 = 4'd7; b4 = 4'd7; c4 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a16 = 16'hffff; b16 = 16'hffff; c16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum",  32'(s4),  32'd0);
        chk("reset_cout", 32'(co4), 32'd0);
        chk("reset_w16",  32'({co16, s16}), 32'd0);

        lit("basic",    4'd2,  4'd3,  1'b0, 4'd5,  1'b0);
        lit("carry",    4'd15, 4'd10, 1'b1, 4'd10, 1'b1);
        lit("wrap",     4'd15, 4'd0,  1'b1, 4'd0,  1'b1);
        lit("maxall",   4'd15, 4'd15, 1'b1, 4'd15, 1'b1);
        lit("zero",     4'd0,  4'd0,  1'b0, 4'd0,  1'b0);

        for (int i = 0; i < 8; i++) begin
            step(bb_a[i], bb_b[i], bb_c[i], bb_r[i]);
            chk($sformatf("b2b_%0d", i), 32'({co4, s4}), 32'(bb_e[i]));
        end

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step(v[3:0], v[7:4], v[8], 1'b1);
        end

        for (int i = 0; i < 500; i++)
            step(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
